// File: rtl/controlador_ordenacao_pkg.sv
// Shared constants and FSM encoding for the 8-word sorting controller.
package controlador_ordenacao_pkg;

  // Words per sort batch; the sort network and counters are sized for this.
  localparam int unsigned N    = 8;
  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SORT   = 2'd1,
    UNLOAD = 2'd2
  } state_e;

endpackage

// File: rtl/controlador_ordenacao_bn.sv
// BN compare-swap cell: orders two unsigned words, equal words pass straight through.
module controlador_ordenacao_bn #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] lo_o,
  output logic [Width-1:0] hi_o
);

  logic swap;

  // Strict compare so equal words never move.
  always_comb begin
    swap = (a_i > b_i);
    lo_o = swap ? b_i : a_i;
    hi_o = swap ? a_i : b_i;
  end

endmodule

// File: rtl/controlador_ordenacao.sv
// Batch sorter: loads 8 words, sorts them by odd-even transposition in 8 cycles,
// then streams them out smallest first.
module controlador_ordenacao
  import controlador_ordenacao_pkg::*;
#(
  parameter int unsigned Size = 8,
  parameter int unsigned N    = controlador_ordenacao_pkg::N
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [Size-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [Size-1:0] out_data,
  output logic            busy
);

  localparam int unsigned NumPairs = N / 2;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  state_e                     state_q;
  logic [CntW-1:0]            load_cnt_q;
  logic [CntW-1:0]            phase_q;
  logic [CntW-1:0]            out_cnt_q;
  logic [N-1:0][Size-1:0]     slot_q;
  logic                       in_ready_q;
  logic                       out_valid_q;
  logic                       busy_q;

  logic [NumPairs-1:0][Size-1:0] bn_a, bn_b, bn_lo, bn_hi;
  logic [N-1:0][Size-1:0]        even_next, odd_next;

  // Odd phases shift the pairing by one slot; the last cell is idle then.
  for (genvar k = 0; k < NumPairs; k++) begin : g_bn
    if (k < NumPairs - 1) begin : g_mux
      assign bn_a[k] = phase_q[0] ? slot_q[2*k+1] : slot_q[2*k];
      assign bn_b[k] = phase_q[0] ? slot_q[2*k+2] : slot_q[2*k+1];
      assign odd_next[2*k+1] = bn_lo[k];
      assign odd_next[2*k+2] = bn_hi[k];
    end else begin : g_fixed
      assign bn_a[k] = slot_q[2*k];
      assign bn_b[k] = slot_q[2*k+1];
    end

    assign even_next[2*k]   = bn_lo[k];
    assign even_next[2*k+1] = bn_hi[k];

    controlador_ordenacao_bn #(
      .Width (Size)
    ) u_bn (
      .a_i  (bn_a[k]),
      .b_i  (bn_b[k]),
      .lo_o (bn_lo[k]),
      .hi_o (bn_hi[k])
    );
  end

  // End slots are outside every odd-phase pair.
  assign odd_next[0]   = slot_q[0];
  assign odd_next[N-1] = slot_q[N-1];

  // Controller FSM: counters, slot storage and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      load_cnt_q  <= '0;
      phase_q     <= '0;
      out_cnt_q   <= '0;
      slot_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (in_valid) begin
            slot_q[load_cnt_q] <= in_data;
            load_cnt_q         <= load_cnt_q + 1'b1;
            if (load_cnt_q == CntLast) begin
              state_q    <= SORT;
              phase_q    <= '0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
        end
        SORT: begin
          slot_q  <= phase_q[0] ? odd_next : even_next;
          phase_q <= phase_q + 1'b1;
          if (phase_q == CntLast) begin
            state_q     <= UNLOAD;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b1;
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            out_cnt_q <= out_cnt_q + 1'b1;
            if (out_cnt_q == CntLast) begin
              state_q     <= LOAD;
              out_cnt_q   <= '0;
              load_cnt_q  <= '0;
              phase_q     <= '0;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= LOAD;
          load_cnt_q  <= '0;
          phase_q     <= '0;
          out_cnt_q   <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = out_valid_q;
    busy      = busy_q;
    out_data  = slot_q[out_cnt_q];
  end

endmodule

// File: tb/tb_controlador_ordenacao.sv
// Directed self-checking bench for the 8-word sorting controller.
module tb_controlador_ordenacao;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] vin  [8];
  logic [7:0] vexp [8];

  always #5 clk = ~clk;

  controlador_ordenacao #(
    .Size (8),
    .N    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Offer vin[0..count-1]; returns #1 after the edge of the last accept.
  task automatic load_words(input int count);
    for (int i = 0; i < count; i++) begin
      int w;
      w = 0;
      in_valid = 1'b1;
      in_data  = vin[i];
      while (!in_ready && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready word %0d: in_ready=%b required 1", i, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 8'hEE;
  endtask

  // Drain one batch against vexp; stall=1 drives out_ready as 1,0,0,1 repeating.
  task automatic unload_words(input int stall, input string name);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s sort_flags: in_ready=%b busy=%b required 0/1", name, in_ready, busy);
      end
      @(posedge clk); #1;
      cyc++;
    end
    cyc = 0;
    while (got < 8 && cyc < 100) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== vexp[got] || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s word %0d: out_valid=%b out_data=%0d in_ready=%b busy=%b required 1/%0d/0/1",
                 name, got, out_valid, out_data, in_ready, busy, vexp[got]);
      end
      if (stall != 0) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else            out_ready = 1'b1;
      @(posedge clk); #1;
      if (out_ready) got++;
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (got != 8) begin
      errors++;
      $display("FAIL %s handshakes: got=%0d required 8", name, got);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end_state: in_ready=%b out_valid=%b busy=%b required 1/0/0",
               name, in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_data=%0d required 1/0/0/0",
               in_ready, out_valid, busy, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_descending();
    for (int i = 0; i < 8; i++) begin
      vin[i]  = 8'(8 - i);
      vexp[i] = 8'(i + 1);
    end
    out_ready = 1'b1;
    load_words(8);
    // Edge T just happened: out_valid must stay low through edge T+7.
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_early edge T+%0d: out_valid=%b required 0", k, out_valid);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_T+8: out_valid=%b required 1", out_valid);
    end
    unload_words(0, "descending");
  endtask

  task automatic test_duplicates();
    vin  = '{8'd5, 8'd5, 8'd0, 8'd255, 8'd5, 8'd0, 8'd1, 8'd1};
    vexp = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd5, 8'd5, 8'd5, 8'd255};
    load_words(8);
    unload_words(0, "duplicates");
  endtask

  task automatic test_stall();
    vin  = '{8'd9, 8'd200, 8'd3, 8'd3, 8'd77, 8'd0, 8'd128, 8'd64};
    vexp = '{8'd0, 8'd3, 8'd3, 8'd9, 8'd64, 8'd77, 8'd128, 8'd200};
    load_words(8);
    unload_words(1, "stall");
  endtask

  task automatic test_reset_mid_load();
    vin = '{8'd200, 8'd201, 8'd202, 8'd203, 8'd0, 8'd0, 8'd0, 8'd0};
    load_words(4);
    rst_n = 1'b0;
    #2;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_load: in_ready=%b busy=%b out_valid=%b required 1/0/0",
               in_ready, busy, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vin  = '{8'd3, 8'd1, 8'd2, 8'd0, 8'd7, 8'd6, 8'd5, 8'd4};
    vexp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    load_words(8);
    unload_words(0, "after_load_reset");
  endtask

  task automatic test_reset_mid_sort();
    vin = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20};
    load_words(8);
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_sort_flags: busy=%b in_ready=%b required 1/0", busy, in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_sort: out_valid=%b busy=%b in_ready=%b out_data=%0d required 0/0/1/0",
               out_valid, busy, in_ready, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    vin  = '{8'hA3, 8'h17, 8'hFF, 8'h00, 8'h5C, 8'h17, 8'h80, 8'h42};
    vexp = '{8'h00, 8'h17, 8'h17, 8'h42, 8'h5C, 8'h80, 8'hA3, 8'hFF};
    load_words(8);
    // A word offered while busy must not be taken.
    in_valid = 1'b1;
    in_data  = 8'h55;
    unload_words(0, "batch_a");
    vin  = '{8'h9E, 8'h01, 8'h6D, 8'hC4, 8'h33, 8'hFE, 8'h02, 8'h7A};
    vexp = '{8'h01, 8'h02, 8'h33, 8'h6D, 8'h7A, 8'h9E, 8'hC4, 8'hFE};
    load_words(8);
    unload_words(1, "batch_b");
  endtask

  initial begin
    test_reset();
    test_descending();
    test_duplicates();
    test_stall();
    test_reset_mid_load();
    test_reset_mid_sort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
